ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/ifetch_unit.sv | 114 +++++++++++
 tb/tb_ifetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch-side definitions: FSM encoding and instruction-buffer entry layout.
package ifetch_pkg;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic            fault;
  } ibuf_entry_t;

  localparam int unsigned ENTRY_W = $bits(ibuf_entry_t);

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; push is accepted on full only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues aligned PC reads, buffers in-order responses for decode,
// turns misaligned PCs into fault entries and drains in-flight reads after a flush.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            flush,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [0:0]      state;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   ibuf_count;
  logic [CW:0]     in_use;
  logic [CW-1:0]   flush_drop;
  logic            abuf_full;
  logic            abuf_empty;
  logic            ibuf_full;
  logic            ibuf_empty;
  logic [XLEN-1:0] abuf_head;
  logic            running;
  logic            req_fire;
  logic            rsp_accept;
  logic            fault_accept;
  logic            ibuf_pop;
  ibuf_entry_t     ibuf_wdata;
  ibuf_entry_t     ibuf_head;

  assign running = (state == RUN) && !reset && !flush;
  assign in_use  = {1'b0, outstanding} + {1'b0, ibuf_count};

  assign imem_req_valid = running && pc_valid && is_aligned(pc_in) && !abuf_full && (in_use < DEPTH_W);
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fault_accept = running && pc_valid && !is_aligned(pc_in) && (outstanding == '0) && !ibuf_full;
  assign pc_ready     = req_fire || fault_accept;

  assign rsp_accept = running && imem_rsp_valid && !abuf_empty;
  assign ibuf_pop   = inst_valid && inst_ready && !flush;

  assign ibuf_wdata = fault_accept ? '{data: '0, pc: pc_in, fault: 1'b1}
                                   : '{data: imem_rsp_data, pc: abuf_head, fault: 1'b0};

  // The address FIFO holds exactly the in-flight reads, so its occupancy is the outstanding count.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (req_fire),
    .pop   (rsp_accept),
    .wdata (pc_in),
    .rdata (abuf_head),
    .count (outstanding),
    .full  (abuf_full),
    .empty (abuf_empty)
  );

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_inst_buf (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (rsp_accept || fault_accept),
    .pop   (ibuf_pop),
    .wdata (ibuf_wdata),
    .rdata (ibuf_head),
    .count (ibuf_count),
    .full  (ibuf_full),
    .empty (ibuf_empty)
  );

  assign inst_valid = !ibuf_empty;
  assign inst_data  = inst_valid ? ibuf_head.data  : '0;
  assign inst_pc    = inst_valid ? ibuf_head.pc    : '0;
  assign inst_fault = inst_valid && ibuf_head.fault;

  // A response arriving in the flush cycle is already discarded, so it is not left to drain.
  assign flush_drop = outstanding - CW'(imem_rsp_valid && (outstanding != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else if (state == RUN) begin
      if (flush) begin
        drop_cnt <= flush_drop;
        state    <= (flush_drop != '0) ? DRAIN : RUN;
      end
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
      if (drop_cnt == CW'(1)) state <= RUN;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed vector bench for ifetch_unit with a 1-cycle in-order memory model.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];

  typedef struct {
    logic [31:0] pc;
    logic        pv, rdy, fl, me;
    logic        e_req, e_pcr, e_iv;
    logic [31:0] e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  ifetch_unit #(.DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] pc, input logic pv, input logic rdy, input logic fl,
                     input logic me, input logic e_req, input logic e_pcr, input logic e_iv,
                     input logic [31:0] e_ipc, input logic e_flt);
    vec_t t;
    t.pc = pc; t.pv = pv; t.rdy = rdy; t.fl = fl; t.me = me;
    t.e_req = e_req; t.e_pcr = e_pcr; t.e_iv = e_iv; t.e_ipc = e_ipc; t.e_flt = e_flt;
    vecs.push_back(t);
  endtask

  // One clock: drive, check handshakes mid-cycle, clock, update memory, check decode outputs.
  task automatic apply(input string tag, input int idx, input vec_t v);
    logic        fire;
    logic [31:0] addr;
    pc_in          = v.pc;
    pc_valid       = v.pv;
    inst_ready     = v.rdy;
    flush          = v.fl;
    imem_req_ready = 1'b1;
    imem_rsp_valid = v.me && (mq.size() > 0);
    imem_rsp_data  = imem_rsp_valid ? mdata(mq[0]) : 32'h0;
    #1;
    chk($sformatf("%s[%0d] imem_req_valid", tag, idx), {31'b0, imem_req_valid}, {31'b0, v.e_req});
    chk($sformatf("%s[%0d] pc_ready", tag, idx), {31'b0, pc_ready}, {31'b0, v.e_pcr});
    if (v.e_req) chk($sformatf("%s[%0d] imem_req_addr", tag, idx), imem_req_addr, v.pc);
    fire = imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (imem_rsp_valid) void'(mq.pop_front());
    if (fire) mq.push_back(addr);
    chk($sformatf("%s[%0d] inst_valid", tag, idx), {31'b0, inst_valid}, {31'b0, v.e_iv});
    if (v.e_iv) begin
      chk($sformatf("%s[%0d] inst_pc", tag, idx), inst_pc, v.e_ipc);
      chk($sformatf("%s[%0d] inst_data", tag, idx), inst_data, v.e_flt ? 32'h0 : mdata(v.e_ipc));
      chk($sformatf("%s[%0d] inst_fault", tag, idx), {31'b0, inst_fault}, {31'b0, v.e_flt});
    end
  endtask

  task automatic run(input string tag);
    foreach (vecs[i]) apply(tag, i, vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    pc_in          = 32'h0;
    pc_valid       = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    flush          = 1'b0;
    inst_ready     = 1'b0;
    #2;
    chk("reset imem_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("reset pc_ready", {31'b0, pc_ready}, 32'h0);
    chk("reset inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset inst_data", inst_data, 32'h0);
    chk("reset inst_pc", inst_pc, 32'h0);
    chk("reset inst_fault", {31'b0, inst_fault}, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    pc_valid = 1'b0;
    @(posedge clk);
    #1;

    // pc, pv, rdy, flush, mem_en | req, pc_ready, inst_valid, inst_pc, fault
    add(32'h0, 1, 1, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'h4, 1, 1, 0, 1,  1, 1,  1, 32'h0, 0);
    add(32'h8, 1, 1, 0, 1,  0, 0,  1, 32'h4, 0);
    add(32'h8, 1, 1, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'hC, 0, 1, 0, 1,  0, 0,  1, 32'h8, 0);
    add(32'hC, 0, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    run("inorder");

    add(32'h0, 1, 0, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'h4, 1, 0, 0, 1,  1, 1,  1, 32'h0, 0);
    add(32'h8, 1, 0, 0, 1,  0, 0,  1, 32'h0, 0);
    add(32'h8, 1, 0, 0, 1,  0, 0,  1, 32'h0, 0);
    add(32'h8, 1, 1, 0, 1,  0, 0,  1, 32'h4, 0);
    add(32'h8, 1, 1, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'hC, 0, 1, 0, 1,  0, 0,  1, 32'h8, 0);
    add(32'hC, 0, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    run("backpressure");

    add(32'h10, 1, 1, 0, 0,  1, 1,  0, 32'h0, 0);
    add(32'h14, 1, 1, 0, 0,  1, 1,  0, 32'h0, 0);
    add(32'h18, 1, 1, 0, 0,  0, 0,  0, 32'h0, 0);
    add(32'h40, 1, 1, 1, 0,  0, 0,  0, 32'h0, 0);
    add(32'h40, 1, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    add(32'h40, 1, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    add(32'h40, 1, 1, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'h44, 0, 1, 0, 1,  0, 0,  1, 32'h40, 0);
    add(32'h44, 0, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    run("flush_drain");

    add(32'h10, 1, 1, 0, 0,  1, 1,  0, 32'h0, 0);
    add(32'h14, 1, 1, 0, 0,  1, 1,  0, 32'h0, 0);
    add(32'h40, 1, 1, 1, 1,  0, 0,  0, 32'h0, 0);
    add(32'h40, 1, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    add(32'h40, 1, 1, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'h44, 0, 1, 0, 1,  0, 0,  1, 32'h40, 0);
    add(32'h44, 0, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    run("flush_with_rsp");

    add(32'h6,  1, 0, 0, 1,  0, 1,  1, 32'h6, 1);
    add(32'h8,  0, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    add(32'h20, 1, 0, 0, 0,  1, 1,  0, 32'h0, 0);
    add(32'h22, 1, 0, 0, 0,  0, 0,  0, 32'h0, 0);
    add(32'h22, 1, 0, 0, 1,  0, 0,  1, 32'h20, 0);
    add(32'h22, 1, 1, 0, 1,  0, 1,  1, 32'h22, 1);
    add(32'h24, 0, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    run("misaligned");

    add(32'h0, 1, 0, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'h4, 1, 0, 0, 1,  1, 1,  1, 32'h0, 0);
    run("pre_reset");

    // Mid-cycle reset with one read in flight and one buffered entry.
    pc_in          = 32'h8;
    pc_valid       = 1'b1;
    inst_ready     = 1'b0;
    flush          = 1'b0;
    imem_rsp_valid = 1'b0;
    reset          = 1'b1;
    #1;
    chk("midreset inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("midreset imem_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("midreset pc_ready", {31'b0, pc_ready}, 32'h0);
    mq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("postreset inst_valid", {31'b0, inst_valid}, 32'h0);

    add(32'h0, 1, 1, 0, 1,  1, 1,  0, 32'h0, 0);
    add(32'h4, 0, 1, 0, 1,  0, 0,  1, 32'h0, 0);
    add(32'h4, 0, 1, 0, 1,  0, 0,  0, 32'h0, 0);
    run("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
